// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter (request, handshake, registered response)
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic          we;
  logic [1:0]    acc_type;
  logic          sign;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;
  modport master (output valid, we, acc_type, sign, addr, wdata, input ready, rvalid, rdata, err);
  modport slave  (input valid, we, acc_type, sign, addr, wdata, output ready, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter (p0 priority, p1 starvation guard, halfword store split, load sign-extension)
// Optional range check of the last accessed byte against [0x100,0x1FFFF] when DMEM_ARB_RANGE_CHECK_EN is defined.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  dmem_arbiter_if.slave            p0,
  dmem_arbiter_if.slave            p1,
  output logic                     mem_we_o,
  output logic [1:0]               mem_type_o,
  output logic                     mem_sign_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {IDLE, HW_HI} state_t;
  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic [CW-1:0]           starve_q, starve_d;
  logic [1:0]              rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                    idle, g1, any, sel, s_we, s_sign, bad, split, done;
  logic [1:0]              eff_type;
  logic [ADDRESS_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0]   s_wdata, load_data, resp;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic [ADDRESS_WIDTH-1:0] last;
`endif
  always_comb begin
    idle     = state_q == IDLE;
    g1       = p1.valid && (starve_q == CW'(STARVE_LIMIT) || !p0.valid);
    any      = idle ? (p0.valid || p1.valid) : 1'b1;
    sel      = idle ? g1 : owner_q;
    s_we     = sel ? p1.we : p0.we;
    s_sign   = sel ? p1.sign : p0.sign;
    s_addr   = sel ? p1.addr : p0.addr;
    s_wdata  = sel ? p1.wdata : p0.wdata;
    eff_type = (sel ? p1.acc_type : p0.acc_type) == 2'b11 ? 2'b01 : (sel ? p1.acc_type : p0.acc_type);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    last     = s_addr + ADDRESS_WIDTH'(eff_type == 2'b00 ? 3 : eff_type == 2'b10 ? 1 : 0);
    bad      = idle && any && (last < ADDRESS_WIDTH'('h100) || last > ADDRESS_WIDTH'('h1FFFF));
`else
    bad      = 1'b0;
`endif
    // a halfword store spends its first cycle on the low byte and completes in HW_HI
    split    = idle && any && s_we && eff_type == 2'b10 && !bad;
    done     = any && !split;
    mem_we_o    = any && s_we && !bad && !rst_i;
    mem_type_o  = (!idle || split) ? 2'b01 : eff_type;
    mem_sign_o  = s_we && eff_type == 2'b00;
    mem_addr_o  = idle ? s_addr : s_addr + ADDRESS_WIDTH'(1);
    mem_wdata_o = !idle ? DATA_WIDTH'(s_wdata[15:8]) : split ? DATA_WIDTH'(s_wdata[7:0]) : s_wdata;
    load_data   = eff_type == 2'b01 ? {{(DATA_WIDTH-8){s_sign && mem_rdata_i[7]}}, mem_rdata_i[7:0]} :
                  eff_type == 2'b10 ? {{(DATA_WIDTH-16){s_sign && mem_rdata_i[15]}}, mem_rdata_i[15:0]} : mem_rdata_i;
    resp        = (bad || s_we) ? '0 : load_data;
    rvalid_d    = {done && sel, done && !sel};
    err_d       = {done && sel && bad, done && !sel && bad};
    rdata0_d    = (done && !sel) ? resp : rdata0_q;
    rdata1_d    = (done && sel) ? resp : rdata1_q;
    state_d     = split ? HW_HI : IDLE;
    owner_d     = split ? sel : owner_q;
    starve_d    = (p1.valid && !(any && sel)) ? (starve_q == CW'(STARVE_LIMIT) ? starve_q : starve_q + CW'(1)) : '0;
  end
  assign p0.ready  = done && !sel;
  assign p1.ready  = done && sel;
  assign p0.rvalid = rvalid_q[0];
  assign p1.rvalid = rvalid_q[1];
  assign p0.err    = err_q[0];
  assign p1.err    = err_q[1];
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed traffic on both ports against a transaction-level model with a shadow byte memory
module tb_dmem_arbiter;
  localparam int LIM = 4;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.AW(32), .DW(32)) p0_if ();
  dmem_arbiter_if #(.AW(32), .DW(32)) p1_if ();
  logic v[2], w_[2], sg[2], rdy[2], rv[2], er[2];
  logic [1:0] ty[2];
  logic [31:0] ad[2], wd[2], rd[2];
  logic mem_we, mem_sign;
  logic [1:0] mem_type;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  assign p0_if.valid = v[0];  assign p1_if.valid = v[1];
  assign p0_if.we = w_[0];    assign p1_if.we = w_[1];
  assign p0_if.acc_type = ty[0]; assign p1_if.acc_type = ty[1];
  assign p0_if.sign = sg[0];  assign p1_if.sign = sg[1];
  assign p0_if.addr = ad[0];  assign p1_if.addr = ad[1];
  assign p0_if.wdata = wd[0]; assign p1_if.wdata = wd[1];
  assign rdy[0] = p0_if.ready;  assign rdy[1] = p1_if.ready;
  assign rv[0] = p0_if.rvalid;  assign rv[1] = p1_if.rvalid;
  assign rd[0] = p0_if.rdata;   assign rd[1] = p1_if.rdata;
  assign er[0] = p0_if.err;     assign er[1] = p1_if.err;
  dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst), .p0(p0_if), .p1(p1_if),
    .mem_we_o(mem_we), .mem_type_o(mem_type), .mem_sign_o(mem_sign),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata));
  logic [7:0] dm [int unsigned];
  logic [7:0] sh [int unsigned];
  int checks = 0, failures = 0;
  int wait1 = 0, hw = -1;
  bit erv[2], eer[2], took[2];
  logic [31:0] ehold[2];
  int gq[$];
  function automatic logic [7:0] rb(input logic [31:0] a);
    return dm.exists(a) ? dm[a] : 8'h00;
  endfunction
  function automatic logic [7:0] shb(input logic [31:0] a);
    return sh.exists(a) ? sh[a] : 8'h00;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // memory: combinational read settled before the checker, write committed at the posedge
  initial begin
    logic cw, cs;
    logic [1:0] ct;
    logic [31:0] ca, cd;
    forever begin
      @(negedge clk); #1;
      mem_rdata = mem_type == 2'b00 ? {rb(mem_addr+3), rb(mem_addr+2), rb(mem_addr+1), rb(mem_addr)} :
                  mem_type == 2'b10 ? {16'h0, rb(mem_addr+1), rb(mem_addr)} : {24'h0, rb(mem_addr)};
      #1;
      cw = mem_we; ct = mem_type; cs = mem_sign; ca = mem_addr; cd = mem_wdata;
      @(posedge clk);
      if (cw === 1'b1) begin
        if (ct == 2'b00 && cs) for (int i = 0; i < 4; i++) dm[ca+i] = cd[8*i +: 8];
        else dm[ca] = cd[7:0];
      end
    end
  end
  task automatic respond(input int p, input logic [31:0] d, input bit e);
    erv[p] = 1'b1; eer[p] = e; ehold[p] = d;
  endtask
  task automatic step();
    int w, n;
    logic [31:0] last, val;
    bit bad;
    if (hw >= 0) begin
      w = hw;
      chk("hw_ready_owner", rdy[w], 1); chk("hw_ready_other", rdy[1-w], 0);
      chk("hw_mem_we", mem_we, 1); chk("hw_mem_type", mem_type, 1);
      chk("hw_mem_addr", mem_addr, ad[w] + 1); chk("hw_mem_wdata", mem_wdata[7:0], wd[w][15:8]);
      sh[ad[w]+1] = wd[w][15:8];
      respond(w, 0, 1'b0);
      wait1 = (v[1] && w != 1) ? ((wait1 < LIM) ? wait1 + 1 : LIM) : 0;
      hw = -1;
      return;
    end
    w = (v[1] && (wait1 == LIM || !v[0])) ? 1 : v[0] ? 0 : -1;
    wait1 = (v[1] && w != 1) ? ((wait1 < LIM) ? wait1 + 1 : LIM) : 0;
    if (w < 0) begin
      chk("idle_ready0", rdy[0], 0); chk("idle_ready1", rdy[1], 0); chk("idle_mem_we", mem_we, 0);
      return;
    end
    n = ty[w] == 2'b00 ? 4 : ty[w] == 2'b10 ? 2 : 1;
    last = ad[w] + n - 1;
    bad = RC && (last < 32'h100 || last > 32'h1FFFF);
    if (bad) begin
      chk("bad_ready", rdy[w], 1); chk("bad_ready_other", rdy[1-w], 0); chk("bad_mem_we", mem_we, 0);
      respond(w, 0, 1'b1);
    end else if (w_[w] && n == 2) begin
      chk("hw_lo_ready0", rdy[0], 0); chk("hw_lo_ready1", rdy[1], 0);
      chk("hw_lo_mem_we", mem_we, 1); chk("hw_lo_mem_type", mem_type, 1);
      chk("hw_lo_mem_addr", mem_addr, ad[w]); chk("hw_lo_mem_wdata", mem_wdata[7:0], wd[w][7:0]);
      sh[ad[w]] = wd[w][7:0];
      hw = w;
    end else if (w_[w]) begin
      chk("st_ready", rdy[w], 1); chk("st_ready_other", rdy[1-w], 0); chk("st_mem_we", mem_we, 1);
      chk("st_mem_type", mem_type, n == 4 ? 0 : 1); chk("st_mem_sign", mem_sign, n == 4 ? 1 : 0);
      chk("st_mem_addr", mem_addr, ad[w]);
      chk("st_mem_wdata", n == 4 ? mem_wdata : {24'h0, mem_wdata[7:0]}, n == 4 ? wd[w] : {24'h0, wd[w][7:0]});
      for (int i = 0; i < n; i++) sh[ad[w]+i] = wd[w][8*i +: 8];
      respond(w, 0, 1'b0);
    end else begin
      chk("ld_ready", rdy[w], 1); chk("ld_ready_other", rdy[1-w], 0); chk("ld_mem_we", mem_we, 0);
      chk("ld_mem_type", mem_type, n == 4 ? 0 : n == 2 ? 2 : 1); chk("ld_mem_sign", mem_sign, 0);
      chk("ld_mem_addr", mem_addr, ad[w]);
      val = 0;
      for (int i = 0; i < n; i++) val = val | (32'(shb(ad[w]+i)) << (8*i));
      if (sg[w] && n < 4 && val >= (32'h1 << (8*n-1))) val = val - (32'h1 << (8*n));
      respond(w, val, 1'b0);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk); #2;
      for (int p = 0; p < 2; p++) begin erv[p] = 1'b0; eer[p] = 1'b0; took[p] = 1'b0; end
      if (rst) begin
        chk("rst_mem_we", mem_we, 0);
        hw = -1; wait1 = 0; ehold[0] = 0; ehold[1] = 0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          took[p] = rdy[p];
          if (rdy[p]) gq.push_back(p);
        end
        step();
      end
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("p%0d_rvalid", p), rv[p], erv[p]);
        chk($sformatf("p%0d_rdata", p), rd[p], ehold[p]);
        chk($sformatf("p%0d_err", p), er[p], erv[p] && eer[p]);
      end
    end
  end
  task automatic req(input int p, input bit w, input logic [1:0] t, input bit s, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    v[p] = 1'b1; w_[p] = w; ty[p] = t; sg[p] = s; ad[p] = a; wd[p] = d;
    for (int i = 0; ; i++) begin
      @(posedge clk);
      if (took[p]) break;
      if (i == 60) begin
        checks++; failures++;
        $display("FAIL req_timeout: port %0d got no ready in 60 cycles, expected ready", p);
        break;
      end
    end
  endtask
  task automatic rand_traffic(input int p, input int cnt);
    logic [31:0] a;
    for (int k = 0; k < cnt; k++) begin
      if ($urandom_range(0, 3) == 0) begin @(negedge clk); v[p] = 1'b0; end
      a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 255)) : 32'h10000 + 32'($urandom_range(0, 255));
      req(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    @(negedge clk); v[p] = 1'b0;
  endtask
  initial begin
    int exp4[6] = '{0, 0, 0, 0, 1, 0};
    logic [7:0] b;
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; w_[p] = 1'b0; ty[p] = 2'b00; sg[p] = 1'b0; ad[p] = '0; wd[p] = '0;
    end
    for (int a = 32'h10000; a < 32'h10104; a++) begin b = 8'($urandom); dm[a] = b; sh[a] = b; end
    repeat (2) @(negedge clk);
    chk("reset_rvalid0", rv[0], 0); chk("reset_rvalid1", rv[1], 0);
    chk("reset_rdata0", rd[0], 0); chk("reset_err1", er[1], 0);
    rst = 1'b0;
    {dm[32'h10003], dm[32'h10002], dm[32'h10001], dm[32'h10000]} = 32'h89ABCDEF;
    {sh[32'h10003], sh[32'h10002], sh[32'h10001], sh[32'h10000]} = 32'h89ABCDEF;
    req(0, 1'b0, 2'b00, 1'b0, 32'h10000, 0);
    @(negedge clk); v[0] = 1'b0;
    chk("t1_rvalid", rv[0], 1); chk("t1_rdata", rd[0], 32'h89ABCDEF);
    dm[32'h10000] = 8'h80; sh[32'h10000] = 8'h80;
    req(0, 1'b0, 2'b01, 1'b1, 32'h10000, 0);
    @(negedge clk); v[0] = 1'b0;
    chk("t2_lb_signed", rd[0], 32'hFFFFFF80);
    req(0, 1'b0, 2'b01, 1'b0, 32'h10000, 0);
    @(negedge clk); v[0] = 1'b0;
    chk("t2_lb_unsigned", rd[0], 32'h00000080);
    req(0, 1'b1, 2'b10, 1'b0, 32'h10010, 32'h0000BEEF);
    @(negedge clk); v[0] = 1'b0;
    chk("t3_ack", rv[0], 1); chk("t3_byte_lo", rb(32'h10010), 8'hEF); chk("t3_byte_hi", rb(32'h10011), 8'hBE);
    req(0, 1'b0, 2'b10, 1'b0, 32'h10010, 0);
    @(negedge clk); v[0] = 1'b0;
    chk("t3_reload", rd[0], 32'h0000BEEF);
    @(negedge clk);
    gq.delete();
    fork
      begin repeat (6) req(0, 1'b0, 2'b00, 1'b0, 32'h10040, 0); @(negedge clk); v[0] = 1'b0; end
      begin repeat (2) req(1, 1'b0, 2'b00, 1'b0, 32'h10080, 0); @(negedge clk); v[1] = 1'b0; end
    join
    chk("t4_grants", gq.size() >= 6, 1);
    for (int i = 0; i < 6 && i < gq.size(); i++) chk($sformatf("t4_grant%0d", i), gq[i], exp4[i]);
    dm[32'h10021] = 8'h55; sh[32'h10021] = 8'h55;
    @(negedge clk);
    v[0] = 1'b1; w_[0] = 1'b1; ty[0] = 2'b10; sg[0] = 1'b0; ad[0] = 32'h10020; wd[0] = 32'h0000BEEF;
    @(negedge clk); rst = 1'b1; v[0] = 1'b0;
    @(negedge clk); rst = 1'b0;
    chk("t5_lo_written", rb(32'h10020), 8'hEF); chk("t5_hi_untouched", rb(32'h10021), 8'h55);
    chk("t5_no_rvalid", rv[0], 0); chk("t5_rdata0", rd[0], 0); chk("t5_rdata1", rd[1], 0);
    req(1, 1'b1, 2'b00, 1'b0, 32'h1FFFE, 32'h12345678);
    @(negedge clk); v[1] = 1'b0;
    chk("t6_rvalid", rv[1], 1);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    chk("t6_err", er[1], 1); chk("t6_not_written", rb(32'h1FFFE), 8'h00);
`else
    chk("t6_err", er[1], 0); chk("t6_written", rb(32'h1FFFE), 8'h78); chk("t6_written_hi", rb(32'h20001), 8'h12);
`endif
    fork
      rand_traffic(0, 150);
      rand_traffic(1, 150);
    join
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
